b2_demux_1_3_tdm: RTL and testbench

B2_DEMUX_1_3_TDM -- requirements
Module: b2_demux_1_3_tdm

---
 rtl/b2_demux_1_3_tdm.sv | 113 +++++++++++
 tb/tb_b2_demux_1_3_tdm.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/b2_demux_1_3_tdm.sv
// rtl/b2_demux_1_3_tdm.sv - 1:3 TDM demultiplexer with sync-word framing.
// Slots 0 and 1 are held in shadow registers until slot 2 arrives, then all three outputs load together.
module b2_demux_1_3_tdm #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             valid,
    input  logic             sync,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic             frame_valid,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] shadow0_q, shadow0_d;
    logic [WIDTH-1:0] shadow1_q, shadow1_d;
    logic [WIDTH-1:0] y0_q, y0_d;
    logic [WIDTH-1:0] y1_q, y1_d;
    logic [WIDTH-1:0] y2_q, y2_d;
    logic             frame_valid_q, frame_valid_d;
    logic             sync_err_q, sync_err_d;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        shadow0_d     = shadow0_q;
        shadow1_d     = shadow1_q;
        y0_d          = y0_q;
        y1_d          = y1_q;
        y2_d          = y2_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (valid) begin
            if (state_q == HUNT) begin
                if (sync) begin
                    shadow0_d = d;
                    slot_d    = 2'd1;
                    state_d   = LOCKED;
                end
            end else if (sync && slot_q != 2'd0) begin
                // Early sync restarts the frame; the outputs keep the last complete frame.
                shadow0_d  = d;
                slot_d     = 2'd1;
                sync_err_d = 1'b1;
            end else begin
                case (slot_q)
                    2'd0: begin
                        shadow0_d = d;
                        slot_d    = 2'd1;
                    end
                    2'd1: begin
                        shadow1_d = d;
                        slot_d    = 2'd2;
                    end
                    2'd2: begin
                        y0_d          = shadow0_q;
                        y1_d          = shadow1_q;
                        y2_d          = d;
                        frame_valid_d = 1'b1;
                        slot_d        = 2'd0;
                    end
                    default: slot_d = 2'd0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            slot_q        <= 2'd0;
            shadow0_q     <= '0;
            shadow1_q     <= '0;
            y0_q          <= '0;
            y1_q          <= '0;
            y2_q          <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            shadow0_q     <= shadow0_d;
            shadow1_q     <= shadow1_d;
            y0_q          <= y0_d;
            y1_q          <= y1_d;
            y2_q          <= y2_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign y0          = y0_q;
    assign y1          = y1_q;
    assign y2          = y2_q;
    assign frame_valid = frame_valid_q;
    assign slot        = slot_q;
    assign locked      = state_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_b2_demux_1_3_tdm.sv
// tb/tb_b2_demux_1_3_tdm.sv - directed vector bench for the 1:3 TDM demultiplexer.
module tb_b2_demux_1_3_tdm;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] d;
    logic       valid;
    logic       sync;
    logic [1:0] y0, y1, y2;
    logic       frame_valid;
    logic [1:0] slot;
    logic       locked;
    logic       sync_err;

    int n_checks = 0;
    int n_fail   = 0;

    b2_demux_1_3_tdm #(.WIDTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .valid      (valid),
        .sync       (sync),
        .y0         (y0),
        .y1         (y1),
        .y2         (y2),
        .frame_valid(frame_valid),
        .slot       (slot),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       s;
        logic [1:0] d;
        logic [1:0] y0;
        logic [1:0] y1;
        logic [1:0] y2;
        logic       fv;
        logic [1:0] slot;
        logic       lk;
        logic       se;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic v, input logic s, input logic [1:0] dd,
                                input logic [1:0] e0, input logic [1:0] e1, input logic [1:0] e2,
                                input logic fv, input logic [1:0] sl, input logic lk, input logic se);
        vec_t r;
        r.v = v; r.s = s; r.d = dd; r.y0 = e0; r.y1 = e1; r.y2 = e2;
        r.fv = fv; r.slot = sl; r.lk = lk; r.se = se;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] e0, input logic [1:0] e1,
                             input logic [1:0] e2, input logic fv, input logic [1:0] sl,
                             input logic lk, input logic se);
        check({tag, ".y0"}, int'(y0), int'(e0));
        check({tag, ".y1"}, int'(y1), int'(e1));
        check({tag, ".y2"}, int'(y2), int'(e2));
        check({tag, ".frame_valid"}, int'(frame_valid), int'(fv));
        check({tag, ".slot"}, int'(slot), int'(sl));
        check({tag, ".locked"}, int'(locked), int'(lk));
        check({tag, ".sync_err"}, int'(sync_err), int'(se));
    endtask

    // Inputs change 1ns after a rising edge; outputs are sampled 1ns after the next one.
    task automatic step(input logic v, input logic s, input logic [1:0] dd);
        valid = v;
        sync  = s;
        d     = dd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //              v  s  d      y0     y1     y2     fv slot  lk se
        vecs[0]  = mk(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'd1, 1, 0);
        vecs[1]  = mk(1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 2'd2, 1, 0);
        vecs[2]  = mk(1, 0, 2'b10, 2'b00, 2'b01, 2'b10, 1, 2'd0, 1, 0);
        vecs[3]  = mk(0, 0, 2'b11, 2'b00, 2'b01, 2'b10, 0, 2'd0, 1, 0);
        vecs[4]  = mk(1, 1, 2'b00, 2'b00, 2'b01, 2'b10, 0, 2'd1, 1, 0);
        vecs[5]  = mk(1, 0, 2'b01, 2'b00, 2'b01, 2'b10, 0, 2'd2, 1, 0);
        vecs[6]  = mk(1, 1, 2'b10, 2'b00, 2'b01, 2'b10, 0, 2'd1, 1, 1);
        vecs[7]  = mk(1, 0, 2'b11, 2'b00, 2'b01, 2'b10, 0, 2'd2, 1, 0);
        vecs[8]  = mk(1, 0, 2'b01, 2'b10, 2'b11, 2'b01, 1, 2'd0, 1, 0);
        vecs[9]  = mk(1, 1, 2'b11, 2'b10, 2'b11, 2'b01, 0, 2'd1, 1, 0);
        vecs[10] = mk(1, 0, 2'b00, 2'b10, 2'b11, 2'b01, 0, 2'd2, 1, 0);
        vecs[11] = mk(1, 0, 2'b01, 2'b11, 2'b00, 2'b01, 1, 2'd0, 1, 0);
        vecs[12] = mk(1, 1, 2'b01, 2'b11, 2'b00, 2'b01, 0, 2'd1, 1, 0);
        vecs[13] = mk(1, 0, 2'b10, 2'b11, 2'b00, 2'b01, 0, 2'd2, 1, 0);
        vecs[14] = mk(1, 0, 2'b11, 2'b01, 2'b10, 2'b11, 1, 2'd0, 1, 0);
        vecs[15] = mk(0, 1, 2'b11, 2'b01, 2'b10, 2'b11, 0, 2'd0, 1, 0);
        vecs[16] = mk(1, 1, 2'b10, 2'b01, 2'b10, 2'b11, 0, 2'd1, 1, 0);
        vecs[17] = mk(0, 1, 2'b00, 2'b01, 2'b10, 2'b11, 0, 2'd1, 1, 0);
        vecs[18] = mk(1, 0, 2'b00, 2'b01, 2'b10, 2'b11, 0, 2'd2, 1, 0);
        vecs[19] = mk(0, 1, 2'b11, 2'b01, 2'b10, 2'b11, 0, 2'd2, 1, 0);
        vecs[20] = mk(1, 0, 2'b01, 2'b10, 2'b00, 2'b01, 1, 2'd0, 1, 0);
        vecs[21] = mk(0, 1, 2'b00, 2'b10, 2'b00, 2'b01, 0, 2'd0, 1, 0);
        vecs[22] = mk(1, 1, 2'b00, 2'b10, 2'b00, 2'b01, 0, 2'd1, 1, 0);
        vecs[23] = mk(1, 1, 2'b11, 2'b10, 2'b00, 2'b01, 0, 2'd1, 1, 1);
        vecs[24] = mk(1, 0, 2'b10, 2'b10, 2'b00, 2'b01, 0, 2'd2, 1, 0);
        vecs[25] = mk(1, 0, 2'b01, 2'b11, 2'b10, 2'b01, 1, 2'd0, 1, 0);

        rst   = 1'b1;
        valid = 1'b0;
        sync  = 1'b0;
        d     = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 2'b00, 2'b00, 2'b00, 0, 2'd0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].v, vecs[i].s, vecs[i].d);
            check_all($sformatf("vec%0d", i), vecs[i].y0, vecs[i].y1, vecs[i].y2,
                      vecs[i].fv, vecs[i].slot, vecs[i].lk, vecs[i].se);
        end

        // Reset between edges with slot at 2 must clear everything without a clock.
        step(1, 1, 2'b01);
        step(1, 0, 2'b10);
        check_all("pre_rst", 2'b11, 2'b10, 2'b01, 0, 2'd2, 1, 0);
        #2 rst = 1'b1;
        #1;
        check_all("async_rst", 2'b00, 2'b00, 2'b00, 0, 2'd0, 0, 0);
        #2 rst = 1'b0;
        step(1, 0, 2'b11);
        check_all("post_rst_nosync", 2'b00, 2'b00, 2'b00, 0, 2'd0, 0, 0);

        // Hunt discards non-sync words, then locks on the sync word.
        step(1, 0, 2'b11);
        check_all("hunt_discard", 2'b00, 2'b00, 2'b00, 0, 2'd0, 0, 0);
        step(1, 1, 2'b01);
        check_all("hunt_lock", 2'b00, 2'b00, 2'b00, 0, 2'd1, 1, 0);
        step(1, 0, 2'b10);
        check_all("hunt_w1", 2'b00, 2'b00, 2'b00, 0, 2'd2, 1, 0);
        step(1, 0, 2'b00);
        check_all("hunt_frame", 2'b01, 2'b10, 2'b00, 1, 2'd0, 1, 0);
        step(0, 0, 2'b00);
        check_all("hunt_hold", 2'b01, 2'b10, 2'b00, 0, 2'd0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
